mult_div_unit: RTL and testbench

Parametrised multicycle multiply/divide unit that owns the HI and LO registers of the multicycle datapath. It accepts signed and unsigned multiply and divide requests through a start/done handshake. It iterates one bit per cycle and writes the 2×WIDTH result into HI/LO. HI/LO feed the datapath write-source mux and can be loaded directly for MTHI/MTLO.

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mult_div_unit_if.sv | 30 +++
 rtl/mdu_sign_fix.sv | 13 +
 rtl/mult_div_unit.sv | 196 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// FSM states and the iteration-counter width helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mdu_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response and HI/LO bundle between the datapath (master) and
// the multiply/divide unit (slave).
interface mult_div_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, err, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, err, hi, lo
  );

endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation: magnitude extraction for signed
// operands and final sign correction of products, quotients and remainders.
module mdu_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit owning HI/LO, one result bit per cycle.
// Define MDU_DIV_EN to build the divider; otherwise divide ops report err.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);

  localparam int CNT_W = clog2(WIDTH + 1);

  mdu_state_e         r_state;
  mdu_state_e         w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_negRes;
  logic               r_err;

  logic               w_signedOp;
  logic               w_isDivReq;
  logic               w_errReq;
  logic               w_accept;
  logic               w_lastIter;
  logic               w_busy;
  logic               w_done;
  logic               w_err;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [2*WIDTH-1:0] w_product;
  logic [2*WIDTH-1:0] w_accNext;
  logic [WIDTH-1:0]   w_resHi;
  logic [WIDTH-1:0]   w_resLo;

  assign w_signedOp = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign w_isDivReq = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
`ifdef MDU_DIV_EN
  assign w_errReq   = w_isDivReq && (bus.b == '0);
`else
  assign w_errReq   = w_isDivReq;
`endif
  assign w_accept   = (r_state == IDLE) && bus.start;
  assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

  mdu_sign_fix #(.WIDTH(WIDTH)) u_magA (
    .i_val (bus.a),
    .i_neg (w_signedOp & bus.a[WIDTH-1]),
    .o_val (w_magA)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_magB (
    .i_val (bus.b),
    .i_neg (w_signedOp & bus.b[WIDTH-1]),
    .o_val (w_magB)
  );

  // Shift-add step: accumulator is {partial product, remaining multiplier bits}
  assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opd} : {(WIDTH + 1){1'b0}});
  assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

  mdu_sign_fix #(.WIDTH(2 * WIDTH)) u_fixProd (
    .i_val (r_acc),
    .i_neg (r_negRes),
    .o_val (w_product)
  );

`ifdef MDU_DIV_EN
  logic               r_isDiv;
  logic               r_negRem;
  logic [WIDTH:0]     w_remShift;
  logic               w_fits;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_divNext;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  // Restoring step: accumulator is {partial remainder, dividend/quotient bits}
  assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_fits     = (w_remShift >= {1'b0, r_opd});
  assign w_diff     = w_remShift[WIDTH-1:0] - r_opd;
  assign w_divNext  = w_fits ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                             : {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fixQuot (
    .i_val (r_acc[WIDTH-1:0]),
    .i_neg (r_negRes),
    .o_val (w_quot)
  );

  mdu_sign_fix #(.WIDTH(WIDTH)) u_fixRem (
    .i_val (r_acc[2*WIDTH-1:WIDTH]),
    .i_neg (r_negRem),
    .o_val (w_rem)
  );

  assign w_accNext = r_isDiv ? w_divNext : w_mulNext;
  assign w_resHi   = r_isDiv ? w_rem  : w_product[2*WIDTH-1:WIDTH];
  assign w_resLo   = r_isDiv ? w_quot : w_product[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_isDiv  <= 1'b0;
      r_negRem <= 1'b0;
    end else if (w_accept) begin
      r_isDiv  <= w_isDivReq;
      r_negRem <= w_signedOp & bus.a[WIDTH-1];
    end
  end
`else
  assign w_accNext = w_mulNext;
  assign w_resHi   = w_product[2*WIDTH-1:WIDTH];
  assign w_resLo   = w_product[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Rejected requests take a single write-suppressed FIX cycle so done lands one edge after start
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_nextState = w_errReq ? FIX : RUN;
      RUN:     if (w_lastIter) w_nextState = FIX;
      FIX:     w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    w_err  = 1'b0;
    case (r_state)
      RUN, FIX: w_busy = 1'b1;
      DONE: begin
        w_done = 1'b1;
        w_err  = r_err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc    <= '0;
      r_opd    <= '0;
      r_cnt    <= '0;
      r_negRes <= 1'b0;
      r_err    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_err    <= w_errReq;
        r_negRes <= w_signedOp & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        if (w_isDivReq) begin
          r_acc <= {{WIDTH{1'b0}}, w_magA};
          r_opd <= w_magB;
        end else begin
          r_acc <= {{WIDTH{1'b0}}, w_magB};
          r_opd <= w_magA;
        end
      end else if (r_state == RUN) begin
        r_acc <= w_accNext;
        r_cnt <= r_cnt + CNT_W'(1);
      end

      if ((r_state == FIX) && !r_err) begin
        r_hi <= w_resHi;
        r_lo <= w_resLo;
      end else if (!w_busy) begin
        if (bus.hi_we) r_hi <= bus.wdata;
        if (bus.lo_we) r_lo <= bus.wdata;
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.err  = w_err;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed and random requests checked
// against an arithmetic reference model; honours MDU_DIV_EN like the design.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    longint      doneCyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  longint      cyc = 0;
  int          assertCount = 0;
  int          failCount = 0;
  int          busyRun = 0;
  exp_t        sbQ[$];
  exp_t        monE;
  logic [31:0] mHi = '0;
  logic [31:0] mLo = '0;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    assertCount++;
    if (actual !== required) begin
      failCount++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  task automatic finishTest();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  endtask

  // Result computed with plain 64-bit arithmetic; SV / and % truncate toward zero
  function automatic exp_t refModel(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] curHi, input logic [31:0] curLo, input longint sampleCyc);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.err = 1'b0;
    e.hi = curHi;
    e.lo = curLo;
    e.doneCyc = sampleCyc + LAT;
    case (op)
      MDU_MULT: begin
        prod = 64'(sa * sb);
        e.hi = prod[63:32];
        e.lo = prod[31:0];
      end
      MDU_MULTU: begin
        prod = {32'd0, a} * {32'd0, b};
        e.hi = prod[63:32];
        e.lo = prod[31:0];
      end
      default: begin
        if (!DIV_EN || b == 32'd0) begin
          e.err = 1'b1;
          e.doneCyc = sampleCyc + 1;
        end else if (op == MDU_DIV) begin
          e.lo = 32'(sa / sb);
          e.hi = 32'(sa % sb);
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        checkOutput("idleTimeout", {63'd0, bus.busy}, 64'd0);
        finishTest();
      end
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic hiWe, input logic loWe, input logic [31:0] wdata, input logic doStart);
    exp_t        e;
    logic [31:0] ldHi;
    logic [31:0] ldLo;
    waitIdle();
    bus.start = doStart;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    bus.hi_we = hiWe;
    bus.lo_we = loWe;
    bus.wdata = wdata;
    ldHi = hiWe ? wdata : mHi;
    ldLo = loWe ? wdata : mLo;
    if (doStart) begin
      e = refModel(op, a, b, ldHi, ldLo, cyc + 1);
      sbQ.push_back(e);
      mHi = e.hi;
      mLo = e.lo;
    end else begin
      mHi = ldHi;
      mLo = ldLo;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (hiWe) checkOutput("directHi", {32'd0, bus.hi}, {32'd0, ldHi});
    if (loWe) checkOutput("directLo", {32'd0, bus.lo}, {32'd0, ldLo});
  endtask

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      busyRun = 0;
    end else begin
      if (bus.busy === 1'b1) busyRun++;
      if (bus.done === 1'b1) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedDone", {63'd0, bus.done}, 64'd0);
        end else begin
          monE = sbQ.pop_front();
          checkOutput("hi", {32'd0, bus.hi}, {32'd0, monE.hi});
          checkOutput("lo", {32'd0, bus.lo}, {32'd0, monE.lo});
          checkOutput("err", {63'd0, bus.err}, {63'd0, monE.err});
          checkOutput("doneCycle", 64'(cyc), 64'(monE.doneCyc));
          checkOutput("busyAtDone", {63'd0, bus.busy}, 64'd0);
          if (!monE.err) checkOutput("busyCycles", 64'(busyRun), 64'(LAT));
        end
        busyRun = 0;
      end else begin
        checkOutput("errWithoutDone", {63'd0, bus.err}, 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] prevHi;
    logic [1:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    int          sel;
    int          guard;

    bus.start = 1'b0;
    bus.op    = '0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checkOutput("resetHi", {32'd0, bus.hi}, 64'd0);
    checkOutput("resetLo", {32'd0, bus.lo}, 64'd0);
    checkOutput("resetBusy", {63'd0, bus.busy}, 64'd0);
    checkOutput("resetDone", {63'd0, bus.done}, 64'd0);
    checkOutput("resetErr", {63'd0, bus.err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released, directed sequence");

    applyStimulus(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, '0, 1'b1);
    applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, 1'b1);

    applyStimulus(MDU_MULT, '0, '0, 1'b1, 1'b0, 32'h11, 1'b0);
    applyStimulus(MDU_MULT, '0, '0, 1'b0, 1'b1, 32'h22, 1'b0);
    applyStimulus(MDU_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, '0, 1'b1);

    prevHi = mHi;
    applyStimulus(MDU_MULTU, 32'd5, 32'd6, 1'b0, 1'b0, '0, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.a     = 32'd7;
    bus.b     = 32'd0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    checkOutput("hiWhileBusy", {32'd0, bus.hi}, {32'd0, prevHi});

    applyStimulus(MDU_MULTU, 32'd3, 32'd5, 1'b1, 1'b1, 32'h55, 1'b1);

    applyStimulus(MDU_MULT, 32'h1234, 32'h5678, 1'b0, 1'b0, '0, 1'b1);
    repeat (8) @(negedge clk);
    #2;
    reset = 1'b0;
    sbQ.delete();
    mHi = '0;
    mLo = '0;
    #1;
    checkOutput("midResetHi", {32'd0, bus.hi}, 64'd0);
    checkOutput("midResetLo", {32'd0, bus.lo}, 64'd0);
    checkOutput("midResetBusy", {63'd0, bus.busy}, 64'd0);
    checkOutput("midResetDone", {63'd0, bus.done}, 64'd0);
    checkOutput("midResetErr", {63'd0, bus.err}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    applyStimulus(MDU_MULT, 32'd3, 32'd4, 1'b0, 1'b0, '0, 1'b1);

    $display("[TB] random sequence");
    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA  = $urandom;
      rB  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rB = '0;
      if (sel == 1) begin
        rA = 32'h8000_0000;
        rB = 32'hFFFF_FFFF;
      end
      if (sel == 2) rB = 32'($urandom_range(1, 15));
      applyStimulus(rOp, rA, rB, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                    $urandom, ($urandom_range(0, 7) != 0));
    end

    guard = 0;
    while (sbQ.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 64'(sbQ.size()), 64'd0);
    finishTest();
  end

endmodule
